// File: rtl/od_echo_meas_if.sv
// Sensor-side bundle of the obstacle-detection echo measurement stage:
// trigger/echo inputs and distance/obstacle/timeout results.
interface od_echo_meas_if #(
  parameter int DIST_W = 10
);
  logic              trigger_signal;
  logic              echo;
  logic [DIST_W-1:0] distance_cm;
  logic              distance_valid;
  logic              obstacle;
  logic              timeout;
  logic              busy;

  modport master (
    output trigger_signal, echo,
    input  distance_cm, distance_valid, obstacle, timeout, busy
  );

  modport slave (
    input  trigger_signal, echo,
    output distance_cm, distance_valid, obstacle, timeout, busy
  );
endinterface

// File: rtl/od_echo_meas.sv
// Ultrasonic echo width measurement: waits for the trigger to end, times the
// echo high pulse and converts it to centimetres by repeated subtraction.
module od_echo_meas #(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_CYC = 1_900_000,
  parameter int CYC_PER_CM  = 2915,
  parameter int DIST_W      = 10,
  parameter int THRESH_CM   = 30
) (
  input  logic           clk,
  input  logic           reset,
  od_echo_meas_if.slave  bus
);

  localparam logic [CNT_W-1:0]  TMO_C = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CPC_C = CNT_W'(CYC_PER_CM);
  localparam logic [DIST_W-1:0] THR_C = DIST_W'(THRESH_CM);

  typedef enum logic [2:0] {
    IDLE, WAIT_RISE, MEASURE, DIVIDE, DONE, TMO
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   rem;
  logic [DIST_W-1:0]  q;
  logic               echo_p0, echo_p1, echo_p2;
  logic               trig_p0;
  logic [DIST_W-1:0]  distance_cm;
  logic               distance_valid, obstacle, timeout, busy;
  logic               echo_rise, trig_fall;
  logic [CNT_W-1:0]   cnt_inc;

  // Quotient sticks at full scale instead of wrapping on very long echoes.
  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign echo_rise = echo_p1 & ~echo_p2;
  assign trig_fall = trig_p0 & ~bus.trigger_signal;
  assign cnt_inc   = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      q              <= '0;
      echo_p0        <= 1'b0;
      echo_p1        <= 1'b0;
      echo_p2        <= 1'b0;
      trig_p0        <= 1'b0;
      distance_cm    <= '0;
      distance_valid <= 1'b0;
      obstacle       <= 1'b0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // p0/p1: metastability synchronizer; p2: edge-detect history
      echo_p0        <= bus.echo;
      echo_p1        <= echo_p0;
      echo_p2        <= echo_p1;
      trig_p0        <= bus.trigger_signal;
      distance_valid <= 1'b0;
      timeout        <= 1'b0;

      case (state)
        IDLE: begin
          if (trig_fall) begin
            state <= WAIT_RISE;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
          end else if (cnt_inc == TMO_C) begin
            state       <= TMO;
            cnt         <= cnt_inc;
            timeout     <= 1'b1;
            distance_cm <= '1;
            obstacle    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        MEASURE: begin
          if (!echo_p1) begin
            state <= DIVIDE;
            rem   <= cnt;
            q     <= '0;
          end else if (cnt == TMO_C) begin
            state       <= TMO;
            timeout     <= 1'b1;
            distance_cm <= '1;
            obstacle    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DIVIDE: begin
          if (rem >= CPC_C) begin
            rem <= rem - CPC_C;
            q   <= sat_inc(q);
          end else begin
            state          <= DONE;
            distance_cm    <= q;
            obstacle       <= (q < THR_C);
            distance_valid <= 1'b1;
          end
        end
        DONE, TMO: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.distance_cm    = distance_cm;
  assign bus.distance_valid = distance_valid;
  assign bus.obstacle       = obstacle;
  assign bus.timeout        = timeout;
  assign bus.busy           = busy;

endmodule
